mem_ctrl_mp: RTL and testbench

Parametrised multi-channel memory controller that serialises NUM_CH independent requesters onto the single byte-wide RAM/IO bus of the CPU. Each channel issues byte, half-word or word reads and writes. The block arbitrates between channels, sequences the bytes little-endian, stalls UART writes while the IO buffer is full, and aborts speculative reads on a pipeline flush. It sits between the cpu top-level memory pins and the ICache/LSB-class clients, replacing the fixed two-port controller.

---
 rtl/mem_ctrl_mp.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_ctrl_mp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_mp.sv
// mem_ctrl_mp: arbitrates NUM_CH requesters onto the byte-wide CPU memory bus, little-endian.
// Optional feature macro MC_ROUND_ROBIN_EN: round-robin arbitration (undefined: fixed priority, ch0 wins).
module mem_ctrl_mp #(
  parameter int unsigned       NUM_CH     = 2,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   io_buffer_full,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic [NUM_CH-1:0]      req_valid,
  input  logic [NUM_CH-1:0]      req_wr,
  input  logic [2*NUM_CH-1:0]    req_size,
  input  logic [32*NUM_CH-1:0]   req_addr,
  input  logic [32*NUM_CH-1:0]   req_wdata,
  output logic [NUM_CH-1:0]      resp_valid,
  output logic [31:0]            resp_rdata
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [2:0]        r_nb, w_nb_nxt;
  logic [31:0]       r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_wr, w_wr_nxt;
  logic [CH_W-1:0]   r_grant, w_grant_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic [31:0]       r_mem_a, w_mem_a_nxt;
  logic [7:0]        r_mem_dout, w_mem_dout_nxt;
  logic              r_mem_wr, w_mem_wr_nxt;
  logic [NUM_CH-1:0] r_resp_valid, w_resp_valid_nxt;
  logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;

  logic [NUM_CH-1:0] w_elig;
  logic              w_gnt_valid;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_sel_wr;
  logic [1:0]        w_sel_size;
  logic [2:0]        w_sel_nb;
  logic              w_sel_stall;
  logic              w_io_stall;
  logic              w_abort;
  logic [4:0]        w_cap_sh;

  // Masked channels sit out any IDLE cycle in which flush is high
  assign w_elig = req_valid & ~(FLUSH_MASK & {NUM_CH{flush}});

`ifdef MC_ROUND_ROBIN_EN
  logic [CH_W-1:0] r_ptr;

  // Search from r_ptr upward first, then wrap to the lowest eligible index
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!w_gnt_valid && w_elig[j] && (CH_W'(j) >= r_ptr)) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = CH_W'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!w_gnt_valid && w_elig[j]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = CH_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (rdy && (r_state == IDLE) && w_gnt_valid) begin
      r_ptr <= (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
    end
  end
`else
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!w_gnt_valid && w_elig[j]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = CH_W'(j);
      end
    end
  end
`endif

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    w_sel_size  = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (CH_W'(j) == w_gnt_idx) begin
        w_sel_addr  = req_addr[32*j +: 32];
        w_sel_wdata = req_wdata[32*j +: 32];
        w_sel_wr    = req_wr[j];
        w_sel_size  = req_size[2*j +: 2];
      end
    end
  end

  assign w_sel_nb    = (w_sel_size == 2'd0) ? 3'd1 : (w_sel_size == 2'd1) ? 3'd2 : 3'd4;
  assign w_sel_stall = w_sel_wr && (w_sel_addr[17:16] == 2'b11) && io_buffer_full;
  assign w_io_stall  = r_wr && (r_addr[17:16] == 2'b11) && io_buffer_full;
  assign w_abort     = flush && FLUSH_MASK[r_grant] && !r_wr;
  // Read data lags its address by one cycle, so the byte on mem_din is index r_cnt-2
  assign w_cap_sh    = 5'({r_cnt - 3'd2, 3'b000});

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_nb_nxt         = r_nb;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wr_nxt         = r_wr;
    w_grant_nxt      = r_grant;
    w_rdata_nxt      = r_rdata;
    w_mem_a_nxt      = r_mem_a;
    w_mem_dout_nxt   = r_mem_dout;
    w_mem_wr_nxt     = 1'b0;
    w_resp_valid_nxt = '0;
    w_resp_rdata_nxt = r_resp_rdata;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = BUSY;
          w_addr_nxt  = w_sel_addr;
          w_wdata_nxt = w_sel_wdata;
          w_wr_nxt    = w_sel_wr;
          w_nb_nxt    = w_sel_nb;
          w_grant_nxt = w_gnt_idx;
          w_rdata_nxt = '0;
          if (w_sel_stall) begin
            w_cnt_nxt = 3'd0;
          end else begin
            w_cnt_nxt      = 3'd1;
            w_mem_a_nxt    = w_sel_addr;
            w_mem_dout_nxt = w_sel_wdata[7:0];
            w_mem_wr_nxt   = w_sel_wr;
          end
        end
      end
      BUSY: begin
        if (r_wr) begin
          if (r_cnt == r_nb) begin
            w_state_nxt               = DONE;
            w_resp_valid_nxt[r_grant] = 1'b1;
            w_resp_rdata_nxt          = '0;
          end else if (!w_io_stall) begin
            w_mem_a_nxt    = r_addr + 32'(r_cnt);
            w_mem_dout_nxt = 8'(r_wdata >> {r_cnt[1:0], 3'b000});
            w_mem_wr_nxt   = 1'b1;
            w_cnt_nxt      = r_cnt + 3'd1;
          end
        end else if (w_abort) begin
          w_state_nxt = IDLE;
        end else begin
          if (r_cnt >= 3'd2) begin
            w_rdata_nxt = r_rdata | (32'(mem_din) << w_cap_sh);
          end
          if (r_cnt < r_nb) begin
            w_mem_a_nxt = r_addr + 32'(r_cnt);
            w_cnt_nxt   = r_cnt + 3'd1;
          end else if (r_cnt == r_nb) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end else begin
            w_state_nxt               = DONE;
            w_resp_valid_nxt[r_grant] = 1'b1;
            w_resp_rdata_nxt          = w_rdata_nxt;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_nb         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_grant      <= '0;
      r_rdata      <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
    end else if (rdy) begin
      r_cnt        <= w_cnt_nxt;
      r_nb         <= w_nb_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wr         <= w_wr_nxt;
      r_grant      <= w_grant_nxt;
      r_rdata      <= w_rdata_nxt;
      r_mem_a      <= w_mem_a_nxt;
      r_mem_dout   <= w_mem_dout_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
    end
  end

  // rdy low and a flush hitting a masked read's DONE cycle must suppress the pulse at once
  assign mem_a      = r_mem_a;
  assign mem_dout   = r_mem_dout;
  assign mem_wr     = r_mem_wr & rdy;
  assign resp_valid = r_resp_valid & {NUM_CH{rdy & ~(w_abort & (r_state == DONE))}};
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// tb_mem_ctrl_mp: directed vectors for mem_ctrl_mp (NUM_CH=2, FLUSH_MASK=01) with a byte-memory responder.
module tb_mem_ctrl_mp;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        flush;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [3:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_ctrl_mp #(.NUM_CH(2), .FLUSH_MASK(2'b01)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .req_valid      (req_valid),
    .req_wr         (req_wr),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: ram_byte = 8'h11;
      32'h101: ram_byte = 8'h22;
      32'h102: ram_byte = 8'h33;
      32'h103: ram_byte = 8'h44;
      default: ram_byte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Memory answers one cycle after the address
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_wr[ch]             = wr;
    req_size[2*ch +: 2]    = size;
    req_addr[32*ch +: 32]  = addr;
    req_wdata[32*ch +: 32] = wdata;
  endtask

  task automatic wait_resp(input int max_cyc);
    int n = 0;
    step();
    while (resp_valid == 2'b00 && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [1:0] exp_gnt;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    step(); step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Word read ch0 @0x100
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0); req_valid = 2'b01;
    step(); chk("rd_a0", mem_a, 32'h100); chk("rd_wr0", 32'(mem_wr), 32'h0);
    step(); chk("rd_a1", mem_a, 32'h101);
    step(); chk("rd_a2", mem_a, 32'h102);
    step(); chk("rd_a3", mem_a, 32'h103);
    step(); chk("rd_no_rsp_c5", 32'(resp_valid), 32'h0);
    step(); chk("rd_rsp_c6", 32'(resp_valid), 32'h1); chk("rd_data", resp_rdata, 32'h44332211);
    req_valid = 2'b00;
    step(); chk("rd_rsp_pulse", 32'(resp_valid), 32'h0);

    // Half write ch1 @0x20
    set_ch(1, 1'b1, 2'd1, 32'h20, 32'h0000ABCD); req_valid = 2'b10;
    step(); chk("hw_wr0", 32'(mem_wr), 32'h1); chk("hw_a0", mem_a, 32'h20); chk("hw_d0", 32'(mem_dout), 32'hCD);
    step(); chk("hw_wr1", 32'(mem_wr), 32'h1); chk("hw_a1", mem_a, 32'h21); chk("hw_d1", 32'(mem_dout), 32'hAB);
    step(); chk("hw_rsp", 32'(resp_valid), 32'h2); chk("hw_rdata", resp_rdata, 32'h0); chk("hw_wr_end", 32'(mem_wr), 32'h0);
    req_valid = 2'b00;
    step();

    // Byte write to IO space, buffer full for three sampled cycles
    set_ch(0, 1'b1, 2'd0, 32'h30000, 32'h5E); req_valid = 2'b01; io_buffer_full = 1'b1;
    step(); chk("io_stall1", 32'(mem_wr), 32'h0);
    step(); chk("io_stall2", 32'(mem_wr), 32'h0);
    step(); io_buffer_full = 1'b0; chk("io_stall3", 32'(mem_wr), 32'h0); chk("io_no_rsp", 32'(resp_valid), 32'h0);
    step(); chk("io_wr", 32'(mem_wr), 32'h1); chk("io_a", mem_a, 32'h30000); chk("io_d", 32'(mem_dout), 32'h5E);
    step(); chk("io_rsp", 32'(resp_valid), 32'h1);
    req_valid = 2'b00;
    step();

    // Flush aborts ch0 word read at its second byte
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0); req_valid = 2'b01;
    step(); chk("fl_a0", mem_a, 32'h100);
    step(); chk("fl_a1", mem_a, 32'h101); flush = 1'b1; req_valid = 2'b00;
    step(); chk("fl_no_rsp", 32'(resp_valid), 32'h0); chk("fl_wr", 32'(mem_wr), 32'h0);
    // Still flushing: masked ch0 ineligible, ch1 write proceeds
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
    set_ch(1, 1'b1, 2'd0, 32'h44, 32'h77); req_valid = 2'b11;
    step(); chk("fl_w_wr", 32'(mem_wr), 32'h1); chk("fl_w_a", mem_a, 32'h44); chk("fl_w_d", 32'(mem_dout), 32'h77);
    step(); chk("fl_w_rsp", 32'(resp_valid), 32'h2);
    req_valid = 2'b00; flush = 1'b0;
    step(); chk("fl_idle", 32'(resp_valid), 32'h0);

    // rdy low freezes a byte write mid-flight
    set_ch(1, 1'b1, 2'd0, 32'h50, 32'h99); req_valid = 2'b10;
    step(); chk("rdy_wr_on", 32'(mem_wr), 32'h1); chk("rdy_a", mem_a, 32'h50);
    rdy = 1'b0; #1; chk("rdy_wr_forced", 32'(mem_wr), 32'h0);
    step(); chk("rdy_hold_wr", 32'(mem_wr), 32'h0); chk("rdy_hold_a", mem_a, 32'h50); chk("rdy_hold_rsp", 32'(resp_valid), 32'h0);
    step(); chk("rdy_hold_rsp2", 32'(resp_valid), 32'h0);
    rdy = 1'b1; #1; chk("rdy_wr_back", 32'(mem_wr), 32'h1);
    step(); chk("rdy_rsp", 32'(resp_valid), 32'h2);
    req_valid = 2'b00;
    step();

    // Both channels reading continuously
    set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
    set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0); req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
`ifdef MC_ROUND_ROBIN_EN
      exp_gnt = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      wait_resp(10);
      chk("arb_gnt", 32'(resp_valid), 32'(exp_gnt));
      chk("arb_data", resp_rdata, (exp_gnt == 2'b01) ? 32'h11 : 32'h22);
    end
    req_valid = 2'b00;
    step();

    // Reset mid-read, then a fresh byte read on ch1
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0); req_valid = 2'b01;
    step(); step(); chk("mr_a1", mem_a, 32'h101);
    rst_n = 1'b0; req_valid = 2'b00; #1;
    chk("mr_rst_a", mem_a, 32'h0);
    chk("mr_rst_wr", 32'(mem_wr), 32'h0);
    chk("mr_rst_rsp", 32'(resp_valid), 32'h0);
    chk("mr_rst_rdata", resp_rdata, 32'h0);
    step(); rst_n = 1'b1;
    set_ch(1, 1'b0, 2'd0, 32'h102, 32'h0); req_valid = 2'b10;
    step(); chk("mr_new_a", mem_a, 32'h102);
    step(); chk("mr_new_no_rsp", 32'(resp_valid), 32'h0);
    step(); chk("mr_new_rsp", 32'(resp_valid), 32'h2); chk("mr_new_data", resp_rdata, 32'h33);
    req_valid = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
